ring_txn_ctrl: RTL and testbench
================================

// Module: ring_txn_ctrl
// PURPOSE
//  Drives the open/commit/rollback strobes of one ring buffer from packet-boundary events.
//  Two instances sit in the MIL/SPI bridge: one for mil->spi (rcontrolMS), one for spi->mil (rcontrolSM).
//  Good packets become visible to the reader atomically; failed packets are discarded.
//  Failures are errored, timed-out, oversized, empty or aborted packets.
//  Also exports per-direction commit/rollback statistics and the last rollback reason to status.
// PARAMETERS
//  TIMEOUT_CYCLES  50000  max clk cycles between words inside an open packet before rollback
//  MAX_WORDS       256    max words per packet; an extra word triggers overflow rollback
//  CNT_W           16     width of word counter and statistics counters
// PORTS
//  clk            in   1      system clock
//  rst            in   1      synchronous reset, active-low (0 = reset)
//  pkt_start      in   1      strobe: first word of a packet is about to be pushed
//  word_strobe    in   1      strobe: one 16-bit word was pushed into the ring buffer
//  pkt_end        in   1      strobe: packet complete (last word already or simultaneously strobed)
//  pkt_error      in   1      strobe: source detected error (parity, framing, bad cmd)
//  mem_free       in   CNT_W  free words in ring buffer (size - memUsed)
//  open           out  1      1-cycle pulse to ring buffer: start transaction
//  commit         out  1      1-cycle pulse: publish transaction
//  rollback       out  1      1-cycle pulse: discard transaction
//  busy           out  1      1 while a transaction is open (OPEN..ROLLBACK)
//  pkt_words      out  CNT_W  words accepted in current packet
//  commit_cnt     out  CNT_W  saturating count of commits
//  rollback_cnt   out  CNT_W  saturating count of rollbacks
//  last_reason    out  3      TRollbackReason of most recent rollback
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE; open/commit/rollback/busy=0; pkt_words=0.
//   Also commit_cnt=rollback_cnt=0 and last_reason=TRB_NONE. Reset mid-packet sends no rollback pulse.
//   Ring buffer is reset by the same rst.
//  All outputs registered. Event at cycle N -> strobe at N+1. Exactly one strobe per cycle.
//  States (TTxnState): IDLE, ACTIVE, COMMIT, ROLLBACK.
//  IDLE: pkt_start -> open=1, pkt_words=0, watchdog reload, go ACTIVE.
//   word_strobe/pkt_end/pkt_error while IDLE are ignored (no strobe, no count).
//  ACTIVE, priority top-down in the same cycle:
//   1 pkt_error                               -> ROLLBACK, reason TRB_ERROR
//   2 pkt_start (new packet while open)       -> ROLLBACK, reason TRB_ABORT, restart flag set
//   3 word_strobe && (pkt_words==MAX_WORDS || mem_free==0) -> ROLLBACK, TRB_OVERFLOW
//   4 pkt_end: total = pkt_words + word_strobe; total==0 -> ROLLBACK, TRB_EMPTY; else -> COMMIT
//   5 watchdog expired                        -> ROLLBACK, TRB_TIMEOUT
//   6 word_strobe alone                       -> pkt_words+1, watchdog reload
//   The word_strobe coincident with pkt_end is counted before the commit decision.
//  COMMIT: commit=1 for one cycle; commit_cnt+1 (saturate at all-ones); -> IDLE.
//  ROLLBACK: rollback=1 for one cycle; rollback_cnt+1 (saturate); last_reason latched.
//   Then -> IDLE, or with restart flag -> ACTIVE with open=1 (the aborting pkt_start is honoured).
//  Inputs arriving during COMMIT/ROLLBACK are ignored, except pkt_start in ROLLBACK without restart.
//   That pkt_start is latched into the restart flag.
//  busy=1 in ACTIVE/COMMIT/ROLLBACK; busy falls the cycle after the final strobe.
//  Watchdog counts from TIMEOUT_CYCLES-1 down to 0 while ACTIVE; expired = (count==0).
//  Counters never wrap; pkt_words holds its value after COMMIT/ROLLBACK until the next open.
// STRUCTURE
//  ServiceProtocol package: typedef enum TTxnState {IDLE, ACTIVE, COMMIT, ROLLBACK}.
//   Also typedef enum logic[2:0] TRollbackReason: TRB_NONE=0, TRB_ERROR=1, TRB_TIMEOUT=2,
//   TRB_OVERFLOW=3, TRB_EMPTY=4, TRB_ABORT=5.
//  Sub-module txn_watchdog(clk, rst, reload, enable, expired).
//   Parameterised by TIMEOUT_CYCLES; down-counter sized with $clog2.
//  Parent wires open/commit/rollback onto IRingBufferControl.master fields.
// TESTING
//  1 start, 4 word_strobes, end -> open at N+1, commit once, pkt_words=4, commit_cnt=1, rollback=0.
//  2 start, 2 words, pkt_error together with pkt_end -> one rollback, last_reason=1, commit never 1.
//  3 MAX_WORDS=4: start, 5 words -> rollback on 5th word+1 cycle, reason=3, pkt_words=4.
//  4 TIMEOUT_CYCLES=10: start, 1 word, idle -> rollback 11 cycles after the word, reason=2.
//  5 start, 3 words, pkt_start -> rollback (reason=5) then open next cycle, busy stays 1.
//   Then 1 word + end -> commit.
//  6 start, 2 words, rst=0 for 1 cycle -> no rollback pulse; all outputs 0; counters 0; busy=0.

Source files
------------

// File: rtl/ring_txn_ctrl_pkg.sv
// Shared types for the ring buffer transaction controller: FSM states and rollback reasons.
package ring_txn_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACTIVE   = 2'd1,
    COMMIT   = 2'd2,
    ROLLBACK = 2'd3
  } TTxnState;

  typedef enum logic [2:0] {
    TRB_NONE     = 3'd0,
    TRB_ERROR    = 3'd1,
    TRB_TIMEOUT  = 3'd2,
    TRB_OVERFLOW = 3'd3,
    TRB_EMPTY    = 3'd4,
    TRB_ABORT    = 3'd5
  } TRollbackReason;

endpackage

// File: rtl/ring_txn_ctrl_watchdog.sv
// Inter-word watchdog: reloads to TIMEOUT_CYCLES-1, counts down while enabled, flags zero.
module txn_watchdog #(
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic reload,
  input  logic enable,
  output logic expired
);
  localparam int W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [W-1:0] Top = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] countQ;

  always_ff @(posedge clk) begin
    if (!rst) begin
      countQ <= Top;
    end else if (reload) begin
      countQ <= Top;
    end else if (enable && countQ != '0) begin
      countQ <= countQ - W'(1);
    end
  end

  assign expired = (countQ == '0);
endmodule

// File: rtl/ring_txn_ctrl.sv
// Turns packet-boundary events into open/commit/rollback strobes for one ring buffer,
// and keeps commit/rollback statistics plus the reason of the latest rollback.
module ring_txn_ctrl
  import ring_txn_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int MAX_WORDS      = 256,
  parameter int CNT_W          = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pkt_start,
  input  logic             word_strobe,
  input  logic             pkt_end,
  input  logic             pkt_error,
  input  logic [CNT_W-1:0] mem_free,
  output logic             open,
  output logic             commit,
  output logic             rollback,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_words,
  output logic [CNT_W-1:0] commit_cnt,
  output logic [CNT_W-1:0] rollback_cnt,
  output logic [2:0]       last_reason
);
  localparam logic [CNT_W-1:0] MaxWords = CNT_W'(MAX_WORDS);

  function automatic logic [CNT_W-1:0] satInc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  TTxnState         state, stateNext;
  TRollbackReason   reasonQ, reasonNext;
  logic             restartQ, restartNext;
  logic [CNT_W-1:0] wordsQ, wordsNext, total;
  logic [CNT_W-1:0] commitCntQ, rollbackCntQ;
  logic             openQ, commitQ, rollbackQ, busyQ;
  logic             wdReload, wdExpired;

  txn_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) uWatchdog (
    .clk    (clk),
    .rst    (rst),
    .reload (wdReload),
    .enable (state == ACTIVE),
    .expired(wdExpired)
  );

  always_comb begin
    stateNext   = state;
    reasonNext  = reasonQ;
    restartNext = restartQ;
    wordsNext   = wordsQ;
    wdReload    = 1'b0;
    total       = wordsQ + CNT_W'(word_strobe);
    unique case (state)
      IDLE: begin
        if (pkt_start) begin
          stateNext = ACTIVE;
          wordsNext = '0;
          wdReload  = 1'b1;
        end
      end
      ACTIVE: begin
        if (pkt_error) begin
          stateNext  = ROLLBACK;
          reasonNext = TRB_ERROR;
        end else if (pkt_start) begin
          stateNext   = ROLLBACK;
          reasonNext  = TRB_ABORT;
          restartNext = 1'b1;
        end else if (word_strobe && (wordsQ == MaxWords || mem_free == '0)) begin
          stateNext  = ROLLBACK;
          reasonNext = TRB_OVERFLOW;
        end else if (pkt_end) begin
          // a word strobed together with pkt_end belongs to the packet being closed
          if (total == '0) begin
            stateNext  = ROLLBACK;
            reasonNext = TRB_EMPTY;
          end else begin
            stateNext = COMMIT;
            wordsNext = total;
          end
        end else if (wdExpired) begin
          stateNext  = ROLLBACK;
          reasonNext = TRB_TIMEOUT;
        end else if (word_strobe) begin
          wordsNext = total;
          wdReload  = 1'b1;
        end
      end
      COMMIT: begin
        stateNext = IDLE;
      end
      ROLLBACK: begin
        restartNext = 1'b0;
        if (restartQ || pkt_start) begin
          stateNext = ACTIVE;
          wordsNext = '0;
          wdReload  = 1'b1;
        end else begin
          stateNext = IDLE;
        end
      end
    endcase
  end

  // Strobes are derived from the upcoming state so each event shows one cycle later
  always_ff @(posedge clk) begin
    if (!rst) begin
      state        <= IDLE;
      reasonQ      <= TRB_NONE;
      restartQ     <= 1'b0;
      wordsQ       <= '0;
      commitCntQ   <= '0;
      rollbackCntQ <= '0;
      openQ        <= 1'b0;
      commitQ      <= 1'b0;
      rollbackQ    <= 1'b0;
      busyQ        <= 1'b0;
    end else begin
      state     <= stateNext;
      reasonQ   <= reasonNext;
      restartQ  <= restartNext;
      wordsQ    <= wordsNext;
      openQ     <= (stateNext == ACTIVE) && (state != ACTIVE);
      commitQ   <= (stateNext == COMMIT);
      rollbackQ <= (stateNext == ROLLBACK);
      busyQ     <= (stateNext != IDLE);
      if (stateNext == COMMIT)   commitCntQ   <= satInc(commitCntQ);
      if (stateNext == ROLLBACK) rollbackCntQ <= satInc(rollbackCntQ);
    end
  end

  assign open         = openQ;
  assign commit       = commitQ;
  assign rollback     = rollbackQ;
  assign busy         = busyQ;
  assign pkt_words    = wordsQ;
  assign commit_cnt   = commitCntQ;
  assign rollback_cnt = rollbackCntQ;
  assign last_reason  = reasonQ;
endmodule

// File: tb/tb_ring_txn_ctrl.sv
// Scoreboard bench for ring_txn_ctrl: directed packets queue expected strobes, a monitor checks them.
module tb_ring_txn_ctrl;
  localparam int CNT_W = 16;
  localparam int K_OPEN = 0, K_COMMIT = 1, K_ROLLBACK = 2;

  typedef struct {
    int kind;
    int cyc;
    int words;
    int reason;
    int ccnt;
    int rcnt;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             pkt_start = 1'b0, word_strobe = 1'b0, pkt_end = 1'b0, pkt_error = 1'b0;
  logic [CNT_W-1:0] mem_free = 16'd100;
  logic             open, commit, rollback, busy;
  logic [CNT_W-1:0] pkt_words, commit_cnt, rollback_cnt;
  logic [2:0]       last_reason;

  ring_txn_ctrl #(.TIMEOUT_CYCLES(10), .MAX_WORDS(4), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pkt_start(pkt_start), .word_strobe(word_strobe),
    .pkt_end(pkt_end), .pkt_error(pkt_error), .mem_free(mem_free),
    .open(open), .commit(commit), .rollback(rollback), .busy(busy),
    .pkt_words(pkt_words), .commit_cnt(commit_cnt), .rollback_cnt(rollback_cnt),
    .last_reason(last_reason)
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  int   lastCyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   mCommits = 0, mRollbacks = 0, mReason = 0;
  exp_t expQ[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int at, input int words);
    exp_t e;
    e.kind = kind; e.cyc = at; e.words = words;
    e.reason = mReason; e.ccnt = mCommits; e.rcnt = mRollbacks;
    expQ.push_back(e);
  endtask

  task automatic step(input logic s, input logic w, input logic e, input logic r);
    pkt_start = s; word_strobe = w; pkt_end = e; pkt_error = r;
    lastCyc = cyc;
    @(posedge clk); #1;
    pkt_start = 1'b0; word_strobe = 1'b0; pkt_end = 1'b0; pkt_error = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic openPkt(input int words);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    push(K_OPEN, lastCyc + 1, 0);
    repeat (words) step(1'b0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic expRollback(input int at, input int words, input int reason);
    mRollbacks++;
    mReason = reason;
    push(K_ROLLBACK, at, words);
  endtask

  // Monitor: every strobe must match the head of the expectation queue
  always @(negedge clk) begin
    if (rst && (open || commit || rollback)) begin
      check("one_strobe", int'(open) + int'(commit) + int'(rollback), 1);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: open=%0d commit=%0d rollback=%0d at cycle %0d, none required",
                 open, commit, rollback, cyc);
      end else begin
        exp_t e;
        e = expQ.pop_front();
        check("strobe_kind", commit ? K_COMMIT : (rollback ? K_ROLLBACK : K_OPEN), e.kind);
        check("strobe_cycle", cyc, e.cyc);
        check("pkt_words", int'(pkt_words), e.words);
        check("last_reason", int'(last_reason), e.reason);
        check("commit_cnt", int'(commit_cnt), e.ccnt);
        check("rollback_cnt", int'(rollback_cnt), e.rcnt);
        check("busy_on_strobe", int'(busy), 1);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL time_limit: simulation still running at %0t", $time);
    $fatal(1, "time limit");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_open", int'(open), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_pkt_words", int'(pkt_words), 0);
    check("rst_commit_cnt", int'(commit_cnt), 0);
    check("rst_last_reason", int'(last_reason), 0);
    rst = 1'b1;
    idle(2);

    // 1: four words then end -> commit with 4 words
    openPkt(4);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    mCommits++;
    push(K_COMMIT, lastCyc + 1, 4);
    idle(3);
    check("t1_busy_after", int'(busy), 0);
    check("t1_words_hold", int'(pkt_words), 4);

    // 2: error coincident with end -> rollback, reason error
    openPkt(2);
    step(1'b0, 1'b0, 1'b1, 1'b1);
    expRollback(lastCyc + 1, 2, 1);
    idle(3);

    // 3: fifth word exceeds MAX_WORDS=4 -> overflow
    openPkt(4);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expRollback(lastCyc + 1, 4, 3);
    idle(3);

    // 4: one word then silence -> timeout 11 cycles after the word
    openPkt(1);
    expRollback(lastCyc + 11, 1, 2);
    idle(14);
    check("t4_busy_after", int'(busy), 0);

    // events while idle are ignored
    step(1'b0, 1'b1, 1'b1, 1'b1);
    idle(2);
    check("idle_words_hold", int'(pkt_words), 1);
    check("idle_busy", int'(busy), 0);

    // ring buffer full -> overflow even below MAX_WORDS
    openPkt(1);
    mem_free = '0;
    step(1'b0, 1'b1, 1'b0, 1'b0);
    expRollback(lastCyc + 1, 1, 3);
    mem_free = 16'd100;
    idle(3);

    // end with no words -> empty
    openPkt(0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    expRollback(lastCyc + 1, 0, 4);
    idle(3);

    // word coincident with end is counted before commit
    openPkt(0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    mCommits++;
    push(K_COMMIT, lastCyc + 1, 1);
    idle(3);

    // 5: new start while open -> abort rollback then immediate reopen
    openPkt(3);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    expRollback(lastCyc + 1, 3, 5);
    push(K_OPEN, lastCyc + 2, 0);
    idle(2);
    check("t5_busy_reopen", int'(busy), 1);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, 1'b0);
    mCommits++;
    push(K_COMMIT, lastCyc + 1, 1);
    idle(3);
    check("t5_commit_cnt", int'(commit_cnt), 3);
    check("t5_rollback_cnt", int'(rollback_cnt), 6);

    // 6: reset mid-packet -> silent clear
    openPkt(2);
    rst = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    check("t6_busy", int'(busy), 0);
    check("t6_pkt_words", int'(pkt_words), 0);
    check("t6_commit_cnt", int'(commit_cnt), 0);
    check("t6_rollback_cnt", int'(rollback_cnt), 0);
    check("t6_last_reason", int'(last_reason), 0);
    check("t6_strobes", int'(open) + int'(commit) + int'(rollback), 0);
    idle(12);
    check("t6_busy_later", int'(busy), 0);

    check("queue_drained", expQ.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
